// File: rtl/dcache_ctrl.sv
// Write-back, write-allocate controller for a 2-way, 16-set, 32-byte-line data cache.
// Turns CPU word accesses into combinational SRAM lookups, writes back dirty victims,
// refills missing lines from the 256-bit memory port and stalls the CPU until done.
module dcache_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  cpu_addr_i,
    input  logic [31:0]  cpu_data_i,
    input  logic         cpu_MemRead_i,
    input  logic         cpu_MemWrite_i,
    output logic [31:0]  cpu_data_o,
    output logic         cpu_stall_o,
    output logic [3:0]   sram_addr_o,
    output logic [24:0]  sram_tag_o,
    output logic [255:0] sram_data_o,
    output logic         sram_enable_o,
    output logic         sram_write_o,
    input  logic [24:0]  sram_tag_i,
    input  logic [255:0] sram_data_i,
    input  logic         sram_hit_i,
    output logic [31:0]  mem_addr_o,
    output logic [255:0] mem_data_o,
    output logic         mem_enable_o,
    output logic         mem_write_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i
);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        READMISS,
        READMISSOK
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [22:0]    victim_tag_reg;
    logic [255:0]   victim_data_reg;
    logic [255:0]   refill_data_reg;

    logic           req;
    logic           is_write;
    logic [22:0]    cpu_tag;
    logic [3:0]     cpu_index;
    logic [7:0]     word_offset;
    logic [255:0]   merged_line;
    logic           unused_addr_bits;

    // A simultaneous read and write strobe is serviced as a write.
    assign req         = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_write    = cpu_MemWrite_i;
    assign cpu_tag     = cpu_addr_i[31:9];
    assign cpu_index   = cpu_addr_i[8:5];
    assign word_offset = {cpu_addr_i[4:2], 5'b0};

    // Byte offset bits are irrelevant for word accesses.
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign sram_enable_o = req;
    assign sram_addr_o   = cpu_index;
    assign cpu_stall_o   = req & ~((state_reg == IDLE) & sram_hit_i);

    // Hit line with the addressed word replaced by the CPU write data.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_merge
            assign merged_line[gi*32 +: 32] = (cpu_addr_i[4:2] == 3'(gi)) ?
                                              cpu_data_i : sram_data_i[gi*32 +: 32];
        end
    endgenerate

    // State register plus victim (taken when a miss leaves IDLE) and refill line latches.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg       <= IDLE;
            victim_tag_reg  <= '0;
            victim_data_reg <= '0;
            refill_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && req && !sram_hit_i) begin
                victim_tag_reg  <= sram_tag_i[22:0];
                victim_data_reg <= sram_data_i;
            end
            if (state_reg == READMISS && mem_ack_i) begin
                refill_data_reg <= mem_data_i;
            end
        end
    end

    // Next-state and output decode; memory outputs are levels held per state.
    always_comb begin
        state_next   = state_reg;
        cpu_data_o   = '0;
        sram_tag_o   = '0;
        sram_data_o  = '0;
        sram_write_o = 1'b0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (sram_hit_i) begin
                        if (is_write) begin
                            sram_write_o = 1'b1;
                            sram_data_o  = merged_line;
                            sram_tag_o   = {2'b11, cpu_tag};
                        end else begin
                            cpu_data_o = sram_data_i[word_offset +: 32];
                        end
                    end else if (sram_tag_i[24:23] == 2'b11) begin
                        state_next = WRITEBACK;
                    end else begin
                        state_next = READMISS;
                    end
                end
            end
            WRITEBACK: begin
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {victim_tag_reg, cpu_index, 5'b0};
                mem_data_o   = victim_data_reg;
                if (mem_ack_i) begin
                    state_next = READMISS;
                end
            end
            READMISS: begin
                mem_enable_o = 1'b1;
                mem_addr_o   = {cpu_tag, cpu_index, 5'b0};
                if (mem_ack_i) begin
                    state_next = READMISSOK;
                end
            end
            READMISSOK: begin
                // Fresh line goes in clean; a pending write dirties it on the retried hit.
                sram_write_o = 1'b1;
                sram_data_o  = refill_data_reg;
                sram_tag_o   = {2'b10, cpu_tag};
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: behavioural 2-way LRU SRAM and latency-programmable
// memory around the controller, scoreboard queues for read data and memory requests.
module tb_dcache_ctrl;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o;
    logic [255:0] sram_data_o;
    logic         sram_enable_o;
    logic         sram_write_o;
    logic [24:0]  sram_tag_i;
    logic [255:0] sram_data_i;
    logic         sram_hit_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [255:0] mem_data_i = '0;
    logic         mem_ack_i = 1'b0;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
        .cpu_MemRead_i(cpu_MemRead_i), .cpu_MemWrite_i(cpu_MemWrite_i),
        .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
        .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    // ---------------- SRAM model: 16 sets x 2 ways, LRU replacement ----------------
    bit          sv    [16][2];
    bit          sd    [16][2];
    bit [22:0]   st    [16][2];
    bit [255:0]  sdat  [16][2];
    bit          slru  [16];
    logic        hit_way;
    logic        lru_way;

    always_comb begin
        sram_hit_i  = 1'b0;
        hit_way     = 1'b0;
        lru_way     = slru[sram_addr_o];
        sram_tag_i  = {sv[sram_addr_o][lru_way], sd[sram_addr_o][lru_way], st[sram_addr_o][lru_way]};
        sram_data_i = sdat[sram_addr_o][lru_way];
        for (int w = 0; w < 2; w++) begin
            if (sv[sram_addr_o][w] && st[sram_addr_o][w] == cpu_addr_i[31:9]) begin
                sram_hit_i  = 1'b1;
                hit_way     = 1'(w);
                sram_tag_i  = {sv[sram_addr_o][w], sd[sram_addr_o][w], st[sram_addr_o][w]};
                sram_data_i = sdat[sram_addr_o][w];
            end
        end
    end

    always @(posedge clk_i) begin
        if (sram_enable_o && sram_write_o) begin
            sv[sram_addr_o][sram_hit_i ? hit_way : lru_way]   <= sram_tag_o[24];
            sd[sram_addr_o][sram_hit_i ? hit_way : lru_way]   <= sram_tag_o[23];
            st[sram_addr_o][sram_hit_i ? hit_way : lru_way]   <= sram_tag_o[22:0];
            sdat[sram_addr_o][sram_hit_i ? hit_way : lru_way] <= sram_data_o;
            slru[sram_addr_o] <= ~(sram_hit_i ? hit_way : lru_way);
        end else if (sram_enable_o && sram_hit_i) begin
            slru[sram_addr_o] <= ~hit_way;
        end
    end

    // ---------------- Memory model ----------------
    logic [255:0] mem_store [logic [31:0]];
    int mem_lat = 10;
    int mem_cnt = 0;
    int inject_req = 0;
    int inject_done = 0;

    function automatic logic [255:0] base_line(input logic [31:0] a);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = a + 32'(i*4) + 32'h1000_0000;
        if (a == 32'h40) l[95:64] = 32'hDEAD_BEEF;
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        if (mem_store.exists(a)) return mem_store[a];
        return base_line(a);
    endfunction

    function automatic logic [255:0] put_word(input logic [255:0] l, input int w, input logic [31:0] d);
        logic [255:0] r;
        r = l;
        r[w*32 +: 32] = d;
        return r;
    endfunction

    // Acks after mem_lat cycles of mem_enable_o; can also emit a stray ack on request.
    always @(posedge clk_i) begin
        #1;
        mem_ack_i = 1'b0;
        if (inject_req != inject_done) begin
            mem_ack_i   = 1'b1;
            inject_done = inject_req;
        end else if (rst_i && mem_enable_o) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                mem_ack_i = 1'b1;
                mem_cnt   = 0;
                if (mem_write_o) mem_store[mem_addr_o] = mem_data_o;
                else             mem_data_i = mem_line(mem_addr_o);
            end
        end else begin
            mem_cnt = 0;
        end
    end

    // ---------------- Scoreboard ----------------
    typedef struct {
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] data;
    } mem_exp_t;

    mem_exp_t     exp_mem_q  [$];
    logic [31:0]  exp_read_q [$];

    task automatic check(input string name, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic push_mem(input logic [31:0] a, input logic w, input logic [255:0] d);
        mem_exp_t m;
        m.addr = a; m.wr = w; m.data = d;
        exp_mem_q.push_back(m);
    endtask

    // One CPU access: drive, follow the stall, check memory requests and the result.
    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input int exp_stall, input string tag);
        int stalls;
        bit prev_wb_ack;
        mem_exp_t m;
        logic [255:0] line_v;
        @(negedge clk_i);
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        cpu_addr_i     = addr;
        cpu_data_i     = wdata;
        #1;
        stalls = 0;
        prev_wb_ack = 1'b0;
        while (cpu_stall_o && stalls < 200) begin
            if (prev_wb_ack) check({tag, "/wb_to_rm_nogap"}, {mem_enable_o, mem_write_o}, 2'b10);
            prev_wb_ack = 1'b0;
            if (mem_enable_o && mem_ack_i) begin
                if (exp_mem_q.size() == 0) begin
                    check({tag, "/unexpected_mem_req"}, mem_addr_o, 32'hFFFF_FFFF);
                end else begin
                    m = exp_mem_q.pop_front();
                    check({tag, "/mem_addr"}, mem_addr_o, m.addr);
                    check({tag, "/mem_write"}, mem_write_o, m.wr);
                    if (m.wr) check({tag, "/mem_wb_data"}, mem_data_o, m.data);
                    prev_wb_ack = mem_write_o;
                end
            end
            stalls++;
            @(negedge clk_i);
            #1;
        end
        if (stalls >= 200) check({tag, "/timeout"}, cpu_stall_o, 1'b0);
        check({tag, "/stall_cycles"}, stalls, exp_stall);
        check({tag, "/mem_reqs_left"}, exp_mem_q.size(), 0);
        if (wr) begin
            line_v = sram_data_o;
            check({tag, "/sram_write"}, sram_write_o, 1'b1);
            check({tag, "/sram_tag"}, sram_tag_o, {2'b11, addr[31:9]});
            check({tag, "/sram_word"}, line_v[int'(addr[4:2])*32 +: 32], wdata);
        end else if (exp_read_q.size() == 0) begin
            check({tag, "/no_expected_read"}, cpu_data_o, 32'hFFFF_FFFF);
        end else begin
            check({tag, "/read_data"}, cpu_data_o, exp_read_q.pop_front());
        end
        $display("[TB] %s addr=%08h stalls=%0d", tag, addr, stalls);
    endtask

    logic [31:0] b2b_exp [8];

    initial begin
        rst_i          = 1'b0;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check("rst/mem_enable", mem_enable_o, 1'b0);
        check("rst/mem_write", mem_write_o, 1'b0);
        check("rst/stall", cpu_stall_o, 1'b0);
        check("rst/sram_enable", sram_enable_o, 1'b0);
        check("rst/sram_write", sram_write_o, 1'b0);
        check("rst/cpu_data", cpu_data_o, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Cold read miss, ack in the 10th READMISS cycle: 1 + 10 + 1 stall cycles.
        mem_lat = 10;
        push_mem(32'h40, 1'b0, '0);
        exp_read_q.push_back(32'h1000_0040);
        access(1, 0, 32'h40, 0, 12, "cold_read_40");
        exp_read_q.push_back(32'hDEAD_BEEF);
        access(1, 0, 32'h48, 0, 0, "hit_read_48");

        // Write hit into the filled line.
        access(0, 1, 32'h44, 32'h1234_5678, 0, "write_hit_44");
        exp_read_q.push_back(32'h1234_5678);
        access(1, 0, 32'h44, 0, 0, "readback_44");

        // Second tag in set 2: clean miss into the empty way, then dirty it.
        mem_lat = 5;
        push_mem(32'h240, 1'b0, '0);
        access(0, 1, 32'h240, 32'hA5A5_0001, 7, "write_miss_240");
        exp_read_q.push_back(32'hA5A5_0001);
        access(1, 0, 32'h240, 0, 0, "readback_240");

        // Third tag: LRU victim 0x40 is dirty -> write-back, then refill of 0x440.
        push_mem(32'h40, 1'b1, put_word(base_line(32'h40), 1, 32'h1234_5678));
        push_mem(32'h440, 1'b0, '0);
        exp_read_q.push_back(32'h1000_0440);
        access(1, 0, 32'h440, 0, 12, "dirty_miss_440");

        // Bring 0x40 back: evicts dirty 0x240 and returns the written-back word.
        push_mem(32'h240, 1'b1, put_word(base_line(32'h240), 0, 32'hA5A5_0001));
        push_mem(32'h40, 1'b0, '0);
        exp_read_q.push_back(32'h1234_5678);
        access(1, 0, 32'h44, 0, 12, "dirty_miss_44");

        // Both strobes high on a hit: serviced as a write.
        access(1, 1, 32'h48, 32'hCAFE_F00D, 0, "rdwr_hit_48");
        exp_read_q.push_back(32'hCAFE_F00D);
        access(1, 0, 32'h48, 0, 0, "readback_48");

        // Back-to-back hits across all eight words of line 0x40.
        for (int i = 0; i < 8; i++) b2b_exp[i] = 32'h1000_0040 + 32'(i*4);
        b2b_exp[1] = 32'h1234_5678;
        b2b_exp[2] = 32'hCAFE_F00D;
        for (int i = 0; i < 8; i++) begin
            exp_read_q.push_back(b2b_exp[i]);
            access(1, 0, 32'h40 + 32'(i*4), 0, 0, $sformatf("b2b_word%0d", i));
        end

        // Reset during READMISS, a stray ack arrives afterwards.
        mem_lat = 1000;
        @(negedge clk_i);
        cpu_MemRead_i  = 1'b1;
        cpu_MemWrite_i = 1'b0;
        cpu_addr_i     = 32'h640;
        #1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk_i);
            #1;
        end
        check("rstmiss/mem_enable_before", mem_enable_o, 1'b1);
        check("rstmiss/mem_addr_before", mem_addr_o, 32'h640);
        check("rstmiss/mem_write_before", mem_write_o, 1'b0);
        rst_i = 1'b0;
        #1;
        check("rstmiss/mem_enable_async", mem_enable_o, 1'b0);
        check("rstmiss/sram_write_async", sram_write_o, 1'b0);
        cpu_MemRead_i = 1'b0;
        #1;
        check("rstmiss/stall_idle", cpu_stall_o, 1'b0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        inject_req++;
        @(negedge clk_i);
        #1;
        check("rstmiss/late_ack_sram_write", sram_write_o, 1'b0);
        check("rstmiss/late_ack_mem_enable", mem_enable_o, 1'b0);
        @(negedge clk_i);
        #1;
        check("rstmiss/after_ack_sram_write", sram_write_o, 1'b0);
        check("rstmiss/after_ack_mem_enable", mem_enable_o, 1'b0);
        mem_lat = 5;
        exp_read_q.push_back(32'h1000_0440);
        access(1, 0, 32'h440, 0, 0, "after_rst_hit_440");

        @(negedge clk_i);
        cpu_MemRead_i = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
